// File: rtl/fifo_protocol_checker.sv
// Shadow model of a synchronous FIFO that checks its flags and registered outputs
// every cycle and keeps sticky error flags, saturating counters and a first-error capture.
module fifo_protocol_checker #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_en,
    input  logic                  clr_stats,
    input  logic                  mon_wr_en,
    input  logic                  mon_rd_en,
    input  logic [DATA_WIDTH-1:0] mon_data_in,
    input  logic [DATA_WIDTH-1:0] mon_data_out,
    input  logic                  mon_wr_ack,
    input  logic                  mon_overflow,
    input  logic                  mon_underflow,
    input  logic                  mon_full,
    input  logic                  mon_empty,
    input  logic                  mon_almostfull,
    input  logic                  mon_almostempty,
    output logic [OCC_W-1:0]      model_count,
    output logic [7:0]            err_flags,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  ok_count,
    output logic                  first_err_vld,
    output logic [7:0]            first_err_code,
    output logic [CNT_WIDTH-1:0]  first_err_cycle
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] exp_data_q;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic [CNT_WIDTH-1:0] stamp_q, stamp_d;

    logic pipe_vld_q, pipe_vld_d;
    logic exp_ack_q, exp_ack_d;
    logic exp_ovf_q, exp_ovf_d;
    logic exp_unf_q, exp_unf_d;
    logic exp_rd_q, exp_rd_d;

    logic [7:0]           flags_q, flags_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] ok_cnt_q, ok_cnt_d;
    logic                 fvld_q, fvld_d;
    logic [7:0]           fcode_q, fcode_d;
    logic [CNT_WIDTH-1:0] fcyc_q, fcyc_d;

    logic       is_full, is_empty, wacc, racc;
    logic [7:0] mis;

    // Model update: a full FIFO only reads, an empty FIFO only writes.
    always_comb begin
        is_full  = (count_q == OCC_W'(DEPTH));
        is_empty = (count_q == '0);
        wacc     = mon_wr_en & ~is_full;
        racc     = mon_rd_en & ~is_empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wacc) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (racc) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (wacc && !racc)      count_d = count_q + 1'b1;
        else if (racc && !wacc) count_d = count_q - 1'b1;

        stamp_d    = stamp_q + 1'b1;
        pipe_vld_d = 1'b1;
        exp_ack_d  = wacc;
        exp_ovf_d  = mon_wr_en & is_full;
        exp_unf_d  = mon_rd_en & is_empty;
        exp_rd_d   = racc;
    end

    // Registered outputs are judged against last cycle's expectation; flags against the current count.
    always_comb begin
        mis    = '0;
        mis[0] = pipe_vld_q & exp_rd_q & (mon_data_out != exp_data_q);
        mis[1] = pipe_vld_q & (mon_wr_ack != exp_ack_q);
        mis[2] = pipe_vld_q & (mon_overflow != exp_ovf_q);
        mis[3] = pipe_vld_q & (mon_underflow != exp_unf_q);
        mis[4] = (mon_full != is_full);
        mis[5] = (mon_empty != is_empty);
        mis[6] = (mon_almostfull != (count_q == OCC_W'(DEPTH - 1)));
        mis[7] = (mon_almostempty != (count_q == OCC_W'(1)));
    end

    always_comb begin
        flags_d   = flags_q;
        err_cnt_d = err_cnt_q;
        ok_cnt_d  = ok_cnt_q;
        fvld_d    = fvld_q;
        fcode_d   = fcode_q;
        fcyc_d    = fcyc_q;
        if (clr_stats) begin
            flags_d   = '0;
            err_cnt_d = '0;
            ok_cnt_d  = '0;
            fvld_d    = 1'b0;
            fcode_d   = '0;
            fcyc_d    = '0;
        end else if (chk_en) begin
            if (mis != '0) begin
                flags_d = flags_q | mis;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                if (!fvld_q) begin
                    fvld_d  = 1'b1;
                    fcode_d = mis;
                    fcyc_d  = stamp_q;
                end
            end else if (ok_cnt_q != '1) begin
                ok_cnt_d = ok_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
            pipe_vld_q <= 1'b0;
            exp_ack_q  <= 1'b0;
            exp_ovf_q  <= 1'b0;
            exp_unf_q  <= 1'b0;
            exp_rd_q   <= 1'b0;
            flags_q    <= '0;
            err_cnt_q  <= '0;
            ok_cnt_q   <= '0;
            fvld_q     <= 1'b0;
            fcode_q    <= '0;
            fcyc_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stamp_q    <= stamp_d;
            pipe_vld_q <= pipe_vld_d;
            exp_ack_q  <= exp_ack_d;
            exp_ovf_q  <= exp_ovf_d;
            exp_unf_q  <= exp_unf_d;
            exp_rd_q   <= exp_rd_d;
            flags_q    <= flags_d;
            err_cnt_q  <= err_cnt_d;
            ok_cnt_q   <= ok_cnt_d;
            fvld_q     <= fvld_d;
            fcode_q    <= fcode_d;
            fcyc_q     <= fcyc_d;
        end
    end

    // Shadow data store with registered read; its output is only trusted when exp_rd_q is set.
    always_ff @(posedge clk) begin
        if (wacc) mem_q[wr_ptr_q] <= mon_data_in;
        exp_data_q <= mem_q[rd_ptr_q];
    end

    assign model_count     = count_q;
    assign err_flags       = flags_q;
    assign err_count       = err_cnt_q;
    assign ok_count        = ok_cnt_q;
    assign first_err_vld   = fvld_q;
    assign first_err_code  = fcode_q;
    assign first_err_cycle = fcyc_q;

endmodule

// File: tb/tb_fifo_protocol_checker.sv
// Drives an ideal FIFO (queue-based) with planted output faults into two checker instances
// (16-bit and 4-bit counters) and compares their statistics against a fault-bookkeeping model.
module tb_fifo_protocol_checker;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          chk_en = 1'b0, clr_stats = 1'b0;
    logic          mon_wr_en = 1'b0, mon_rd_en = 1'b0;
    logic [DW-1:0] mon_data_in = '0, mon_data_out = '0;
    logic          mon_wr_ack = 1'b0, mon_overflow = 1'b0, mon_underflow = 1'b0;
    logic          mon_full = 1'b0, mon_empty = 1'b1, mon_almostfull = 1'b0, mon_almostempty = 1'b0;

    logic [OCC_W-1:0] mc16, mc4;
    logic [7:0]       fl16, fl4, fc16, fc4;
    logic [15:0]      ec16, ok16, fy16;
    logic [3:0]       ec4, ok4, fy4;
    logic             fv16, fv4;

    fifo_protocol_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr_stats(clr_stats),
        .mon_wr_en(mon_wr_en), .mon_rd_en(mon_rd_en), .mon_data_in(mon_data_in),
        .mon_data_out(mon_data_out), .mon_wr_ack(mon_wr_ack), .mon_overflow(mon_overflow),
        .mon_underflow(mon_underflow), .mon_full(mon_full), .mon_empty(mon_empty),
        .mon_almostfull(mon_almostfull), .mon_almostempty(mon_almostempty),
        .model_count(mc16), .err_flags(fl16), .err_count(ec16), .ok_count(ok16),
        .first_err_vld(fv16), .first_err_code(fc16), .first_err_cycle(fy16)
    );

    fifo_protocol_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .chk_en(chk_en), .clr_stats(clr_stats),
        .mon_wr_en(mon_wr_en), .mon_rd_en(mon_rd_en), .mon_data_in(mon_data_in),
        .mon_data_out(mon_data_out), .mon_wr_ack(mon_wr_ack), .mon_overflow(mon_overflow),
        .mon_underflow(mon_underflow), .mon_full(mon_full), .mon_empty(mon_empty),
        .mon_almostfull(mon_almostfull), .mon_almostempty(mon_almostempty),
        .model_count(mc4), .err_flags(fl4), .err_count(ec4), .ok_count(ok4),
        .first_err_vld(fv4), .first_err_code(fc4), .first_err_cycle(fy4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Ideal FIFO state plus the statistics a correct checker should report.
    logic [DW-1:0] q[$];
    logic [DW-1:0] r_data;
    bit            r_ack, r_ovf, r_unf, pipe_vld, prev_racc;
    int            stamp, err_n, ok_n, fstamp;
    bit            fvld;
    logic [7:0]    flags, fcode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input int n, input int maxv);
        return (n > maxv) ? 64'(maxv) : 64'(n);
    endfunction

    task automatic check_all();
        check("model_count",     64'(mc16), 64'(q.size()));
        check("model_count4",    64'(mc4),  64'(q.size()));
        check("err_flags",       64'(fl16), 64'(flags));
        check("err_flags4",      64'(fl4),  64'(flags));
        check("err_count",       64'(ec16), sat(err_n, 65535));
        check("err_count4",      64'(ec4),  sat(err_n, 15));
        check("ok_count",        64'(ok16), sat(ok_n, 65535));
        check("ok_count4",       64'(ok4),  sat(ok_n, 15));
        check("first_err_vld",   64'(fv16), 64'(fvld));
        check("first_err_code",  64'(fc16), 64'(fcode));
        check("first_err_cycle", 64'(fy16), 64'(fstamp % 65536));
        check("first_err_cyc4",  64'(fy4),  64'(fstamp % 16));
    endtask

    task automatic model_reset();
        q.delete();
        r_data = '0; r_ack = 0; r_ovf = 0; r_unf = 0;
        pipe_vld = 0; prev_racc = 0; stamp = 0;
        err_n = 0; ok_n = 0; fstamp = 0; fvld = 0; flags = '0; fcode = '0;
    endtask

    task automatic do_reset();
        mon_wr_en = 0; mon_rd_en = 0; chk_en = 0; clr_stats = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One FIFO cycle. fault[i] flips the FIFO output that check bit i watches.
    task automatic step(input bit wr, input bit rd, input logic [DW-1:0] din,
                        input logic [7:0] fault, input bit en, input bit clr);
        int c;
        bit wacc_m, racc_m;
        logic [7:0] live, emis;
        c      = q.size();
        wacc_m = wr && (c < DEPTH);
        racc_m = rd && (c > 0);
        mon_wr_en       = wr;
        mon_rd_en       = rd;
        mon_data_in     = din;
        chk_en          = en;
        clr_stats       = clr;
        mon_full        = (c == DEPTH)     ^ fault[4];
        mon_empty       = (c == 0)         ^ fault[5];
        mon_almostfull  = (c == DEPTH - 1) ^ fault[6];
        mon_almostempty = (c == 1)         ^ fault[7];
        mon_data_out    = r_data ^ DW'(fault[0]);
        mon_wr_ack      = r_ack ^ fault[1];
        mon_overflow    = r_ovf ^ fault[2];
        mon_underflow   = r_unf ^ fault[3];
        live = {4'hF, {3{pipe_vld}}, pipe_vld & prev_racc};
        emis = fault & live;
        @(posedge clk); #1;
        if (racc_m) r_data = q.pop_front();
        if (wacc_m) q.push_back(din);
        r_ack = wacc_m;
        r_ovf = wr && (c == DEPTH);
        r_unf = rd && (c == 0);
        prev_racc = racc_m;
        pipe_vld = 1;
        if (clr) begin
            flags = '0; err_n = 0; ok_n = 0; fvld = 0; fcode = '0; fstamp = 0;
        end else if (en) begin
            if (emis != '0) begin
                flags |= emis;
                err_n++;
                if (!fvld) begin
                    fvld = 1; fcode = emis; fstamp = stamp;
                end
            end else begin
                ok_n++;
            end
        end
        stamp++;
        check_all();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Idle, 8 writes, 8 reads: all clean.
        step(0, 0, '0, '0, 1, 0);
        for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), '0, 1, 0);
        for (int i = 0; i < 8; i++)  step(0, 1, '0, '0, 1, 0);
        check("t1_ok17", 64'(ok16), 64'd17);
        check("t1_err0", 64'(ec16), 64'd0);

        // Overflow while full, with a spurious wr_ack.
        for (int i = 0; i < 8; i++) step(1, 0, DW'($urandom), '0, 1, 0);
        step(1, 0, 16'hBEEF, '0, 1, 1);
        step(0, 0, '0, 8'h02, 1, 0);
        check("t2_count8", 64'(mc16), 64'd8);
        check("t2_flag_ack", 64'(fl16), 64'h02);
        check("t2_errcnt1", 64'(ec16), 64'd1);

        // Underflow missing after a read while empty.
        for (int i = 0; i < 8; i++) step(0, 1, '0, '0, 1, 0);
        step(0, 1, '0, '0, 1, 1);
        step(0, 0, '0, 8'h08, 1, 0);
        check("t3_code", 64'(fc16), 64'h08);

        // Pointer wrap at constant occupancy 3.
        for (int i = 0; i < 3; i++) step(1, 0, DW'($urandom), '0, 1, (i == 0));
        for (int i = 0; i < 20; i++) step(1, 1, DW'($urandom), '0, 1, 0);
        check("t4_count3", 64'(mc16), 64'd3);
        check("t4_err0", 64'(ec16), 64'd0);

        // Data corruption at stamp 12, then a later empty-flag error.
        do_reset();
        for (int i = 0; i < 16; i++)
            step(i < 6, i >= 6, DW'(16'h0100 + i), (i == 12) ? 8'h01 : (i == 14) ? 8'h20 : 8'h00, 1, 0);
        check("t5_fvld", 64'(fv16), 64'd1);
        check("t5_fcyc12", 64'(fy16), 64'd12);
        check("t5_fcode", 64'(fc16), 64'h01);

        // Saturation of the 4-bit counter, then reset mid-burst.
        step(0, 0, '0, '0, 1, 1);
        for (int i = 0; i < 20; i++) step(i < 4, 0, DW'($urandom), 8'h10, 1, 0);
        check("t6_sat15", 64'(ec4), 64'd15);
        check("t6_err20", 64'(ec16), 64'd20);
        for (int i = 0; i < 3; i++) step(1, 0, DW'($urandom), 8'h10, 1, 0);
        do_reset();
        check("t6_rst_err", 64'({ec16, ec4}), 64'd0);

        // Randomised traffic with sparse faults, gaps in chk_en and occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] f;
            f = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            step(1'($urandom), 1'($urandom), DW'($urandom), f,
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
